// File: rtl/pe_mac_param.sv
// pe_mac_param: parametrised systolic-array processing element.
// Two operand FIFOs (A, B) are popped in lockstep, the pair is forwarded
// to the east/south neighbours and multiplied; products are accumulated over
// max_cntr pairs, then shifted, clamped and presented on s_out with a se pulse.
//
// Handshake: the operand path fires (pops both FIFO heads) exactly when
// both FIFOs hold data and neither downstream FIFO reports full; a_ov/b_ov
// are one-cycle valids that act as the neighbours' write enables, and
// a_dn_full/b_dn_full are their ready signals (inverted). There is no
// result-side back-pressure: se is a pure strobe.

// Small synchronous FIFO with start-of-cycle full/empty evaluation.
module pe_mac_fifo #(
    parameter int DW = 16,
    parameter int FD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          nonempty_o,
    output logic [DW-1:0] head_o
);
    localparam int PW   = $clog2(FD);
    localparam int CNTW = PW + 1;

    logic [DW-1:0]   mem_q [FD];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            push, pop;

    assign full_o     = (cnt_q == CNTW'(FD));
    assign nonempty_o = (cnt_q != '0);
    assign head_o     = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; both flags come from the current count.
    always_comb begin
        push     = we_i & ~full_o;
        pop      = pop_i & nonempty_o;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CNTW'(push) - CNTW'(pop);
    end

    // Storage array; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module pe_mac_param #(
    parameter int DW = 16,
    parameter int AW = 40,
    parameter int CW = 8,
    parameter int FD = 4,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a_in,
    input  logic          awe,
    output logic          aff,
    input  logic [DW-1:0] b_in,
    input  logic          bwe,
    output logic          bff,
    output logic [DW-1:0] a_out,
    output logic          a_ov,
    input  logic          a_dn_full,
    output logic [DW-1:0] b_out,
    output logic          b_ov,
    input  logic          b_dn_full,
    input  logic [CW-1:0] max_cntr,
    input  logic          sgn,
    input  logic [SW-1:0] shamt,
    output logic [DW-1:0] s_out,
    output logic          se,
    output logic          sat
);
    localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic        [AW-1:0] UMAX = {{(AW-DW){1'b0}}, {DW{1'b1}}};

    logic          a_ne, b_ne, fire;
    logic [DW-1:0] a_head, b_head;

    pe_mac_fifo #(.DW(DW), .FD(FD)) u_a_fifo (
        .clk(clk), .rst(rst), .we_i(awe), .wdata_i(a_in), .pop_i(fire),
        .full_o(aff), .nonempty_o(a_ne), .head_o(a_head)
    );

    pe_mac_fifo #(.DW(DW), .FD(FD)) u_b_fifo (
        .clk(clk), .rst(rst), .we_i(bwe), .wdata_i(b_in), .pop_i(fire),
        .full_o(bff), .nonempty_o(b_ne), .head_o(b_head)
    );

    // Both streams advance together, and only when both neighbours can take data.
    assign fire = a_ne & b_ne & ~a_dn_full & ~b_dn_full;

    // Stage 1 registers: forwarded operands and the extended product.
    logic [DW-1:0]   a_out_q, a_out_d, b_out_q, b_out_d;
    logic            a_ov_q, b_ov_q, p_v_q;
    logic [AW-1:0]   prod_q, prod_d;
    logic [2*DW-1:0] prod_s, prod_u;
    logic [AW-1:0]   prod_ext;

    // Stage 2 registers: accumulator, pair counter and result.
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d, last;
    logic [DW-1:0] s_out_q, s_out_d;
    logic          sat_q, sat_d, se_d;
    logic          se_q;
    logic [AW-1:0]        sum, r_u;
    logic signed [AW-1:0] r_s;
    logic [DW-1:0]        clamp_val;
    logic                 clamp_sat;

    // Stage 1 next-state: capture heads and form the signed/unsigned product.
    always_comb begin
        prod_s   = $signed({{DW{a_head[DW-1]}}, a_head}) * $signed({{DW{b_head[DW-1]}}, b_head});
        prod_u   = {{DW{1'b0}}, a_head} * {{DW{1'b0}}, b_head};
        prod_ext = sgn ? {{(AW-2*DW){prod_s[2*DW-1]}}, prod_s}
                       : {{(AW-2*DW){1'b0}}, prod_u};
        a_out_d  = fire ? a_head : a_out_q;
        b_out_d  = fire ? b_head : b_out_q;
        prod_d   = fire ? prod_ext : prod_q;
    end

    // Final-sum shift and clamp; floor rounding falls out of the shift.
    always_comb begin
        last      = (max_cntr == '0) ? '0 : max_cntr - CW'(1);
        sum       = acc_q + prod_q;
        r_s       = $signed(sum) >>> shamt;
        r_u       = sum >> shamt;
        clamp_val = r_u[DW-1:0];
        clamp_sat = 1'b0;
        if (sgn) begin
            clamp_val = r_s[DW-1:0];
            if (r_s > SMAX) begin
                clamp_val = SMAX[DW-1:0];
                clamp_sat = 1'b1;
            end else if (r_s < SMIN) begin
                clamp_val = SMIN[DW-1:0];
                clamp_sat = 1'b1;
            end
        end else if (r_u > UMAX) begin
            clamp_val = UMAX[DW-1:0];
            clamp_sat = 1'b1;
        end
    end

    // Stage 2 next-state: accumulate, or emit the result on the last pair.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        s_out_d = s_out_q;
        sat_d   = sat_q;
        se_d    = 1'b0;
        if (p_v_q) begin
            if (cnt_q != last) begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end else begin
                acc_d   = '0;
                cnt_d   = '0;
                s_out_d = clamp_val;
                sat_d   = clamp_sat;
                se_d    = 1'b1;
            end
        end
    end

    // Pipeline registers; reset drops partial sums and in-flight products.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out_q <= '0;
            b_out_q <= '0;
            a_ov_q  <= 1'b0;
            b_ov_q  <= 1'b0;
            p_v_q   <= 1'b0;
            prod_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            s_out_q <= '0;
            sat_q   <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
            a_ov_q  <= fire;
            b_ov_q  <= fire;
            p_v_q   <= fire;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            s_out_q <= s_out_d;
            sat_q   <= sat_d;
            se_q    <= se_d;
        end
    end

    assign a_out = a_out_q;
    assign b_out = b_out_q;
    assign a_ov  = a_ov_q;
    assign b_ov  = b_ov_q;
    assign s_out = s_out_q;
    assign sat   = sat_q;
    assign se    = se_q;
endmodule

// File: tb/tb_pe_mac_param.sv
// Testbench for pe_mac_param: directed steps plus a short random phase,
// with a result scoreboard and forwarded-operand scoreboards.
module tb_pe_mac_param;
    localparam int DW = 16;
    localparam int AW = 40;
    localparam int CW = 8;
    localparam int FD = 4;
    localparam int SW = 5;

    logic          clk, rst;
    logic [DW-1:0] a_in, b_in, a_out, b_out, s_out;
    logic          awe, bwe, aff, bff, a_ov, b_ov, a_dn_full, b_dn_full;
    logic          se, sat, sgn;
    logic [CW-1:0] max_cntr;
    logic [SW-1:0] shamt;

    int checks = 0;
    int errors = 0;

    logic [DW:0]   exp_q[$];
    logic [DW-1:0] a_fwd_q[$];
    logic [DW-1:0] b_fwd_q[$];
    longint        m_acc;
    int            m_n;

    pe_mac_param #(.DW(DW), .AW(AW), .CW(CW), .FD(FD), .SW(SW)) dut (
        .clk(clk), .rst(rst),
        .a_in(a_in), .awe(awe), .aff(aff),
        .b_in(b_in), .bwe(bwe), .bff(bff),
        .a_out(a_out), .a_ov(a_ov), .a_dn_full(a_dn_full),
        .b_out(b_out), .b_ov(b_ov), .b_dn_full(b_dn_full),
        .max_cntr(max_cntr), .sgn(sgn), .shamt(shamt),
        .s_out(s_out), .se(se), .sat(sat)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: accumulate products, emit shifted/clamped result per group.
    task automatic model_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint p, r, lo, hi;
        int grp;
        logic s;
        logic [DW-1:0] v;
        if (sgn) p = longint'($signed(a)) * longint'($signed(b));
        else     p = longint'(a) * longint'(b);
        m_acc += p;
        m_n++;
        grp = (max_cntr == 0) ? 1 : int'(max_cntr);
        if (m_n == grp) begin
            r  = m_acc >>> shamt;
            lo = sgn ? -32768 : 0;
            hi = sgn ? 32767 : 65535;
            s  = 1'b0;
            v  = r[DW-1:0];
            if (r > hi) begin s = 1'b1; v = hi[DW-1:0]; end
            else if (r < lo) begin s = 1'b1; v = lo[DW-1:0]; end
            exp_q.push_back({s, v});
            m_acc = 0;
            m_n   = 0;
        end
    endtask

    // Driver: write one pair; accept says whether the bench expects it to be used.
    task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit accept);
        a_in = a;
        b_in = b;
        awe  = 1'b1;
        bwe  = 1'b1;
        if (accept) begin
            a_fwd_q.push_back(a);
            b_fwd_q.push_back(b);
            model_add(a, b);
        end
        tick();
        awe = 1'b0;
        bwe = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || a_fwd_q.size() != 0 || b_fwd_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_out"}, a_out, 0);
        check({tag, "_b_out"}, b_out, 0);
        check({tag, "_a_ov"}, a_ov, 0);
        check({tag, "_b_ov"}, b_ov, 0);
        check({tag, "_s_out"}, s_out, 0);
        check({tag, "_se"}, se, 0);
        check({tag, "_sat"}, sat, 0);
        check({tag, "_aff"}, aff, 0);
        check({tag, "_bff"}, bff, 0);
    endtask

    // Scoreboard monitor: forwarded operands and results, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (a_ov === 1'b1) begin
                if (a_fwd_q.size() == 0) check("a_ov_unexpected", a_ov, 0);
                else check("a_fwd", a_out, a_fwd_q.pop_front());
            end
            if (b_ov === 1'b1) begin
                if (b_fwd_q.size() == 0) check("b_ov_unexpected", b_ov, 0);
                else check("b_fwd", b_out, b_fwd_q.pop_front());
            end
            if (se === 1'b1) begin
                if (exp_q.size() == 0) check("se_unexpected", se, 0);
                else check("result", {sat, s_out}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; awe = 1'b0; bwe = 1'b0; a_in = '0; b_in = '0;
        a_dn_full = 1'b0; b_dn_full = 1'b0;
        max_cntr = 8'd4; sgn = 1'b1; shamt = '0;
        m_acc = 0; m_n = 0;
        tick();
        check_reset_outputs("init");
        tick();
        rst = 1'b0;
        tick();

        // Test 1: signed dot product of 4 pairs, with latency check.
        for (int i = 0; i < 4; i++) send_pair(DW'(i + 1), DW'(i + 5), 1'b1);
        @(negedge clk); check("t1_lat_se0", se, 0);
        @(negedge clk); check("t1_last_a_ov", a_ov, 1); check("t1_lat_se1", se, 0);
        @(negedge clk); check("t1_se", se, 1); check("t1_s_out", {sat, s_out}, {1'b0, 16'd70});
        @(negedge clk); check("t1_se_pulse", se, 0);
        drain();

        // Test 2: positive and negative saturation.
        for (int i = 0; i < 4; i++) send_pair(16'd200, 16'd200, 1'b1);
        drain();
        check("t2_sat_hi", {sat, s_out}, {1'b1, 16'h7FFF});
        max_cntr = 8'd1;
        send_pair(16'hFED4, 16'd200, 1'b1);
        drain();
        check("t2_sat_lo", {sat, s_out}, {1'b1, 16'h8000});

        // Test 3: output shift with floor rounding.
        max_cntr = 8'd4; shamt = 5'd2;
        for (int i = 0; i < 4; i++) send_pair(DW'(i + 1), DW'(i + 5), 1'b1);
        drain();
        check("t3_shift", {sat, s_out}, {1'b0, 16'd17});
        max_cntr = 8'd1; shamt = 5'd1;
        send_pair(16'hFFFD, 16'd1, 1'b1);
        drain();
        check("t3_floor", {sat, s_out}, {1'b0, 16'hFFFE});

        // Test 4: unsigned mode, edge of range and clamp.
        sgn = 1'b0; shamt = '0; max_cntr = 8'd1;
        send_pair(16'hFFFF, 16'd1, 1'b1);
        drain();
        check("t4_umax", {sat, s_out}, {1'b0, 16'hFFFF});
        send_pair(16'hFFFF, 16'hFFFF, 1'b1);
        drain();
        check("t4_usat", {sat, s_out}, {1'b1, 16'hFFFF});

        // max_cntr=0 behaves as 1; then back-to-back single-pair results.
        sgn = 1'b1; max_cntr = 8'd0;
        send_pair(16'd7, 16'hFFFE, 1'b1);
        drain();
        check("mc0_result", {sat, s_out}, {1'b0, 16'hFFF2});
        max_cntr = 8'd1;
        send_pair(16'd3, 16'd4, 1'b1);
        send_pair(16'd5, 16'd6, 1'b1);
        send_pair(16'hFFFF, 16'd9, 1'b1);
        drain();

        // Test 5: downstream full stalls both streams; FIFO fills, 5th write dropped.
        max_cntr = 8'd4;
        a_dn_full = 1'b1;
        for (int i = 0; i < 4; i++) send_pair(DW'(i + 1), DW'(i + 5), 1'b1);
        check("t5_aff", aff, 1);
        check("t5_bff", bff, 1);
        send_pair(16'd99, 16'd99, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("t5_stall_a_ov", a_ov, 0);
        end
        tick();
        a_dn_full = 1'b0;
        @(negedge clk); check("t5_rel_a_ov0", a_ov, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("t5_burst_a_ov", a_ov, 1);
        end
        @(negedge clk); check("t5_end_a_ov", a_ov, 0);
        check("t5_s_out", {se, sat, s_out}, {1'b1, 1'b0, 16'd70});
        drain();

        // Test 6: reset mid-accumulation, with one pair left in the FIFO.
        send_pair(16'd1, 16'd5, 1'b1);
        send_pair(16'd2, 16'd6, 1'b1);
        repeat (3) tick();
        a_dn_full = 1'b1;
        send_pair(16'd9, 16'd9, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        m_acc = 0; m_n = 0;
        tick();
        check_reset_outputs("t6");
        rst = 1'b0;
        a_dn_full = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send_pair(DW'(i + 1), DW'(i + 5), 1'b1);
        drain();
        check("t6_replay", {sat, s_out}, {1'b0, 16'd70});

        // Random groups under random back-pressure; writes respect full.
        for (int g = 0; g < 8; g++) begin
            max_cntr = CW'($urandom_range(1, 3));
            sgn      = 1'($urandom_range(0, 1));
            shamt    = SW'($urandom_range(0, 3));
            for (int p = 0; p < int'(max_cntr); p++) begin
                int tries;
                tries = 0;
                a_dn_full = ($urandom_range(0, 3) == 0);
                b_dn_full = ($urandom_range(0, 3) == 0);
                while ((aff || bff) && tries < 20) begin
                    a_dn_full = 1'b0;
                    b_dn_full = 1'b0;
                    tick();
                    tries++;
                end
                send_pair(DW'($urandom_range(0, 65535)), DW'($urandom_range(0, 65535)), 1'b1);
            end
            a_dn_full = 1'b0;
            b_dn_full = 1'b0;
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_mac_param.md
Name: pe_mac_param

Overview:
- Parametrised systolic-array processing element, successor to the fixed 16-bit PE.
- Each operand path (A, B) has its own input FIFO. Heads are popped in lockstep and multiply-accumulated over max_cntr pairs, then the result is output.
- Operands are forwarded to the neighbouring PEs (A east, B south) with back-pressure from their FIFOs.
- Adds signed/unsigned mode, a programmable output right-shift, parametrised widths and FIFO depth.

Parameters:
- DW, 16, operand and s_out width.
- AW, 40, accumulator width; must be >= 2*DW + CW so accumulation never wraps.
- CW, 8, width of max_cntr and the internal pair counter.
- FD, 4, depth of each input FIFO; power of 2, >= 2.
- SW, 5, width of shamt.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a_in  in  DW  A operand write data
- awe  in  1  A FIFO write enable
- aff  out  1  A FIFO full
- b_in  in  DW  B operand write data
- bwe  in  1  B FIFO write enable
- bff  out  1  B FIFO full
- a_out  out  DW  forwarded A operand
- a_ov  out  1  a_out valid; drives the east neighbour's awe
- a_dn_full  in  1  east neighbour's aff
- b_out  out  DW  forwarded B operand
- b_ov  out  1  b_out valid; drives the south neighbour's bwe
- b_dn_full  in  1  south neighbour's bff
- max_cntr  in  CW  pairs per result; 0 is treated as 1
- sgn  in  1  1 = two's-complement operands and result, 0 = unsigned
- shamt  in  SW  right shift applied to the final sum
- s_out  out  DW  result
- se  out  1  result strobe, one-cycle pulse
- sat  out  1  s_out was clamped

Behaviour:
- Reset (rst=1 at a clk edge):
  - Both FIFOs empty, accumulator and counter 0, pipeline valids 0.
  - All outputs 0.
  - rst mid-accumulation discards partial sums, FIFO contents and in-flight products.
- FIFOs:
  - Write when we=1 and full=0; a write while full is silently dropped.
  - aff/bff are combinational from occupancy: full = (count == FD).
  - Full and empty are evaluated from the start-of-cycle state. When full, a same-cycle pop does not admit a write. When empty, a same-cycle write is accepted but cannot be popped that cycle.
- Fire condition (combinational): fire = A nonempty & B nonempty & ~a_dn_full & ~b_dn_full.
  - On fire, both heads are popped at the clk edge.
- Stage 1, edge after the fire cycle:
  - a_out/b_out take the popped heads; a_ov/b_ov = 1 for exactly one cycle (0 when no fire).
  - The product register takes a_head * b_head, signed or unsigned per sgn, width 2*DW, extended to AW. p_v = 1.
- Stage 2, edge after p_v:
  - If cnt != last, where last = (max_cntr == 0 ? 0 : max_cntr - 1): acc += prod, cnt += 1.
  - If cnt == last:
    - sum = acc + prod.
    - r = sum >> shamt; arithmetic shift when sgn=1, logical when sgn=0 (floor rounding).
    - Clamp r to [-2^(DW-1), 2^(DW-1)-1] when sgn=1, or to [0, 2^DW-1] when sgn=0.
    - s_out = clamped value; sat = 1 if a clamp occurred, else 0; se = 1.
    - acc = 0, cnt = 0.
  - s_out and sat hold until the next result; se returns to 0 the next cycle.
- Latency and throughput:
  - se is high two cycles after the fire cycle of the last pair.
  - Throughput is one pair per cycle. Back-to-back results are allowed (max_cntr=1 gives se every cycle).
- Control stability: max_cntr, sgn and shamt are sampled live and must be held stable from the first pair of a result until its se. Changing them mid-sequence is undefined.
- Back-pressure: while a_dn_full or b_dn_full = 1, no pop occurs, so both operand streams stall together. The pipeline ahead still drains.
- No result-side back-pressure: the consumer must accept s_out on se.

Test Plan:
1. DW=16, sgn=1, shamt=0, max_cntr=4; write A=1,2,3,4 and B=5,6,7,8 on consecutive cycles -> se once, s_out=70, sat=0. a_out shows 1..4 with a_ov pulses and b_out shows 5..8. se occurs 2 cycles after the 4th fire.
2. sgn=1, max_cntr=4, A=B=200 x4 -> sum 160000 -> s_out=32767, sat=1. Then max_cntr=1, A=-300, B=200 -> s_out=-32768, sat=1.
3. sgn=1, shamt=2, vectors of test 1 -> s_out=17. Then sgn=1, shamt=1, max_cntr=1, A=-3, B=1 -> s_out=-2 (floor).
4. sgn=0, max_cntr=1, A=16'hFFFF, B=1 -> s_out=65535, sat=0. Then A=B=16'hFFFF -> s_out=65535, sat=1.
5. FD=4, hold a_dn_full=1, write 5 pairs -> aff=bff=1 after the 4th, 5th dropped, no a_ov. Release -> 4 pairs forwarded on consecutive cycles, s_out=70 for test-1 data.
6. rst after 2 of 4 pairs of test 1, then replay all 4 pairs -> s_out=70 (partial sum discarded). All outputs 0 in the cycle after reset.
